// File: rtl/fsm_step_controller.sv
// State-register sequencer: debounced step/run/load buttons and an auto-run
// timer advance q through the external decoder's next-state network.
module fsm_step_controller #(
    parameter int         DEBOUNCE    = 5,
    parameter int         PERIOD      = 50,
    parameter logic [2:0] RESET_STATE = 3'b110
) (
    input  logic       hz100,
    input  logic       reset,
    input  logic       step_btn,
    input  logic       run_btn,
    input  logic       load_btn,
    input  logic [2:0] load_val,
    input  logic [2:0] next_q_in,
    output logic [2:0] q,
    output logic [1:0] mode,
    output logic       step_pulse,
    output logic [7:0] step_count
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int TM_W = $clog2(PERIOD);
    localparam logic [TM_W-1:0] TM_LAST = TM_W'(PERIOD - 1);
    localparam int STEP = 0;
    localparam int RUN  = 1;
    localparam int LOAD = 2;

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        HALT   = 2'b10
    } mode_t;

    logic [2:0] btn_raw;
    logic [2:0] btn_rise;   // level rose at the last edge: pulse arrives next cycle
    logic [2:0] btn_pulse;

    assign btn_raw = {load_btn, run_btn, step_btn};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic            level_d_reg;
            logic            pulse_reg;
            logic [DB_W-1:0] db_cnt_reg;

            always_ff @(posedge hz100) begin
                if (reset) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    pulse_reg   <= 1'b0;
                    db_cnt_reg  <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == level_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_W'(DEBOUNCE - 1)) begin
                        level_reg  <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                    level_d_reg <= level_reg;
                    pulse_reg   <= level_reg & ~level_d_reg;
                end
            end

            assign btn_rise[gi]  = level_reg & ~level_d_reg;
            assign btn_pulse[gi] = pulse_reg;
        end
    endgenerate

    mode_t           mode_reg, mode_next;
    logic [2:0]      q_reg, q_next;
    logic [7:0]      count_reg, count_next;
    logic [TM_W-1:0] timer_reg, timer_next;
    logic            step_pulse_reg, step_pulse_next;
    logic            tick_now;
    logic            write_now;

    // Arbitration outcome "does this cycle write q?" for a given set of requests.
    function automatic logic decides_write(input logic pl, input logic pr, input logic ps,
                                           input mode_t md, input logic tick, input logic moves);
        if (pl)
            return 1'b1;
        if (pr)
            return 1'b0;
        if (ps && md == MANUAL)
            return 1'b1;
        return (md == AUTO) && tick && moves;
    endfunction

    always_ff @(posedge hz100) begin
        if (reset) begin
            mode_reg       <= MANUAL;
            q_reg          <= RESET_STATE;
            count_reg      <= '0;
            timer_reg      <= '0;
            step_pulse_reg <= 1'b0;
        end else begin
            mode_reg       <= mode_next;
            q_reg          <= q_next;
            count_reg      <= count_next;
            timer_reg      <= timer_next;
            step_pulse_reg <= step_pulse_next;
        end
    end

    always_comb begin
        mode_next       = mode_reg;
        q_next          = q_reg;
        count_next      = count_reg;
        timer_next      = '0;
        step_pulse_next = 1'b0;

        tick_now  = (mode_reg == AUTO) && (timer_reg == TM_LAST);
        write_now = decides_write(btn_pulse[LOAD], btn_pulse[RUN], btn_pulse[STEP],
                                  mode_reg, tick_now, next_q_in != q_reg);

        if (btn_pulse[LOAD]) begin
            if (mode_reg == HALT)
                mode_next = MANUAL;
        end else if (btn_pulse[RUN]) begin
            mode_next = (mode_reg == MANUAL) ? AUTO : MANUAL;
        end else if (tick_now && next_q_in == q_reg) begin
            mode_next = HALT;
        end

        if (write_now) begin
            q_next     = btn_pulse[LOAD] ? load_val : next_q_in;
            count_next = count_reg + 8'd1;
        end

        if (mode_reg == AUTO && mode_next == AUTO && !write_now && !tick_now)
            timer_next = timer_reg + 1'b1;

        // step_pulse is registered, so the next cycle's decision is made one edge
        // early. A tick never directly follows a q write (timer restarts), so
        // next_q_in already reflects the q of the tick cycle.
        step_pulse_next = decides_write(btn_rise[LOAD], btn_rise[RUN], btn_rise[STEP],
                                        mode_next, (mode_next == AUTO) && (timer_next == TM_LAST),
                                        next_q_in != q_reg);
    end

    assign q          = q_reg;
    assign mode       = mode_reg;
    assign step_pulse = step_pulse_reg;
    assign step_count = count_reg;

endmodule

// File: tb/tb_fsm_step_controller.sv
// Directed + random bench for fsm_step_controller against a cycle model built
// from the button/arbitration rules (sample history, cycle timestamps).
module tb_fsm_step_controller;

    localparam int DB  = 2;
    localparam int PER = 4;

    logic       hz100 = 1'b0;
    logic       reset = 1'b1;
    logic       step_btn = 1'b0;
    logic       run_btn = 1'b0;
    logic       load_btn = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic [2:0] next_q_in;
    logic [2:0] q;
    logic [1:0] mode;
    logic       step_pulse;
    logic [7:0] step_count;

    int total = 0;
    int bad   = 0;
    bit force_self = 1'b0;

    always #5 hz100 = ~hz100;

    function automatic logic [2:0] succ(input logic [2:0] s, input bit fs);
        if (fs && s == 3'd5)
            return 3'd5;
        case (s)
            3'd6:    return 3'd2;
            3'd2:    return 3'd1;
            3'd1:    return 3'd5;
            3'd5:    return 3'd3;
            3'd3:    return 3'd0;
            3'd0:    return 3'd7;
            3'd7:    return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    assign next_q_in = succ(q, force_self);

    fsm_step_controller #(
        .DEBOUNCE(DB),
        .PERIOD(PER),
        .RESET_STATE(3'b110)
    ) dut (
        .hz100(hz100),
        .reset(reset),
        .step_btn(step_btn),
        .run_btn(run_btn),
        .load_btn(load_btn),
        .load_val(load_val),
        .next_q_in(next_q_in),
        .q(q),
        .mode(mode),
        .step_pulse(step_pulse),
        .step_count(step_count)
    );

    // Reference model state
    bit         hist_q[3][$];   // raw level seen at each edge since reset
    bit         smp_q[3][$];    // synchronized samples, last DB kept
    bit         m_lvl[3];
    bit         m_rose[3];
    bit         m_pulse[3];
    logic [2:0] m_q;
    logic [1:0] m_mode;
    logic [7:0] m_count;
    int         m_n;
    int         m_anchor;
    bit         d_write;
    logic [2:0] d_val;
    logic [1:0] d_mode;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            hist_q[b].delete();
            smp_q[b].delete();
            m_lvl[b]   = 1'b0;
            m_rose[b]  = 1'b0;
            m_pulse[b] = 1'b0;
        end
        m_q      = 3'd6;
        m_mode   = 2'd0;
        m_count  = 8'd0;
        m_n      = 0;
        m_anchor = 0;
    endtask

    // Action taken in the current cycle, from priority rules and elapsed time.
    task automatic model_decide(input logic [2:0] lv);
        bit tick;
        tick    = (m_mode == 2'd1) && (m_n - m_anchor == PER);
        d_write = 1'b0;
        d_val   = m_q;
        d_mode  = m_mode;
        if (m_pulse[2]) begin
            d_write = 1'b1;
            d_val   = lv;
            if (m_mode == 2'd2)
                d_mode = 2'd0;
        end else if (m_pulse[1]) begin
            d_mode = (m_mode == 2'd0) ? 2'd1 : 2'd0;
        end else if (m_pulse[0] && m_mode == 2'd0) begin
            d_write = 1'b1;
            d_val   = succ(m_q, force_self);
        end else if (tick) begin
            if (succ(m_q, force_self) == m_q) begin
                d_mode = 2'd2;
            end else begin
                d_write = 1'b1;
                d_val   = succ(m_q, force_self);
            end
        end
    endtask

    task automatic model_button(input int b, input bit v);
        bit smp;
        bit flip;
        smp = (hist_q[b].size() >= 2) ? hist_q[b][hist_q[b].size() - 2] : 1'b0;
        hist_q[b].push_back(v);
        if (hist_q[b].size() > 4)
            void'(hist_q[b].pop_front());
        smp_q[b].push_back(smp);
        if (smp_q[b].size() > DB)
            void'(smp_q[b].pop_front());
        flip = (smp_q[b].size() == DB);
        for (int i = 0; i < smp_q[b].size(); i++)
            if (smp_q[b][i] == m_lvl[b])
                flip = 1'b0;
        m_pulse[b] = m_rose[b];
        m_rose[b]  = flip && !m_lvl[b];
        if (flip)
            m_lvl[b] = !m_lvl[b];
    endtask

    task automatic model_apply(input bit rst, input bit s, input bit r, input bit l);
        if (rst) begin
            model_reset();
        end else begin
            if (d_write) begin
                m_q     = d_val;
                m_count = m_count + 8'd1;
            end
            if (d_write || d_mode != m_mode)
                m_anchor = m_n;
            m_mode = d_mode;
            model_button(0, s);
            model_button(1, r);
            model_button(2, l);
            m_n++;
        end
    endtask

    task automatic cyc(input bit rst, input bit s, input bit r, input bit l,
                       input logic [2:0] lv, input bit chk);
        reset    = rst;
        step_btn = s;
        run_btn  = r;
        load_btn = l;
        load_val = lv;
        model_decide(lv);
        if (chk) begin
            check("step_pulse", {7'd0, step_pulse}, {7'd0, d_write});
            check("q", {5'd0, q}, {5'd0, m_q});
            check("mode", {6'd0, mode}, {6'd0, m_mode});
            check("step_count", step_count, m_count);
        end
        @(posedge hz100);
        model_apply(rst, s, r, l);
        #1;
    endtask

    task automatic hold(input bit s, input bit r, input bit l, input logic [2:0] lv, input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, s, r, l, lv, 1'b1);
    endtask

    initial begin
        int         chg_val[$];
        int         chg_at[$];
        logic [2:0] prev;
        logic [7:0] cb;
        int         guard;
        bit         rs, rr, rl, rst;

        model_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        check("rst_q", {5'd0, q}, 8'd6);
        check("rst_mode", {6'd0, mode}, 8'd0);
        check("rst_count", step_count, 8'd0);

        // Held step button: one step only
        hold(1, 0, 0, 0, 20);
        check("held_q", {5'd0, q}, 8'd2);
        check("held_count", step_count, 8'd1);
        hold(0, 0, 0, 0, 6);

        // Bouncy press: 1,0,1,0 then steady
        hold(1, 0, 0, 0, 1);
        hold(0, 0, 0, 0, 1);
        hold(1, 0, 0, 0, 1);
        hold(0, 0, 0, 0, 1);
        hold(1, 0, 0, 0, 10);
        hold(0, 0, 0, 0, 6);
        check("bounce_q", {5'd0, q}, 8'd1);
        check("bounce_count", step_count, 8'd2);

        // Auto-run: 1 -> 5 -> 3 -> 0 every PER cycles
        hold(0, 1, 0, 0, 4);
        hold(0, 0, 0, 0, 3);
        check("auto_mode", {6'd0, mode}, 8'd1);
        prev = q;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
            if (q !== prev) begin
                chg_val.push_back(int'(q));
                chg_at.push_back(i);
                prev = q;
            end
        end
        check("auto_nchg", 8'(chg_val.size()), 8'd3);
        if (chg_val.size() >= 3) begin
            check("auto_v0", 8'(chg_val[0]), 8'd5);
            check("auto_v1", 8'(chg_val[1]), 8'd3);
            check("auto_v2", 8'(chg_val[2]), 8'd0);
            check("auto_gap1", 8'(chg_at[1] - chg_at[0]), 8'(PER));
            check("auto_gap2", 8'(chg_at[2] - chg_at[1]), 8'(PER));
        end
        hold(1, 0, 0, 0, 4);
        hold(0, 0, 0, 0, 4);
        hold(0, 1, 0, 0, 4);
        hold(0, 0, 0, 0, 3);
        check("stop_mode", {6'd0, mode}, 8'd0);
        hold(0, 0, 0, 0, 10);

        // Self-loop at 5 halts auto-run; load recovers
        force_self = 1'b1;
        hold(0, 1, 0, 0, 4);
        hold(0, 0, 0, 0, 50);
        check("halt_mode", {6'd0, mode}, 8'd2);
        check("halt_q", {5'd0, q}, 8'd5);
        hold(0, 0, 1, 3, 4);
        hold(0, 0, 0, 3, 4);
        check("load_q", {5'd0, q}, 8'd3);
        check("load_mode", {6'd0, mode}, 8'd0);
        force_self = 1'b0;

        // Load and step in the same cycle: load wins, one count
        cb = m_count;
        hold(1, 0, 1, 7, 4);
        hold(0, 0, 0, 7, 4);
        check("ld_st_q", {5'd0, q}, 8'd7);
        check("ld_st_count", step_count, 8'(cb + 8'd1));

        // Count wrap 255 -> 0
        guard = 0;
        while (m_count != 8'd255 && guard < 300) begin
            hold(1, 0, 0, 0, 4);
            hold(0, 0, 0, 0, 4);
            guard++;
        end
        check("count_255", step_count, 8'd255);
        hold(1, 0, 0, 0, 4);
        hold(0, 0, 0, 0, 4);
        check("count_wrap", step_count, 8'd0);

        // Reset in the middle of auto-run
        hold(0, 1, 0, 0, 4);
        hold(0, 0, 0, 0, 8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        check("midrst_q", {5'd0, q}, 8'd6);
        check("midrst_mode", {6'd0, mode}, 8'd0);
        check("midrst_count", step_count, 8'd0);
        hold(0, 0, 0, 0, 4);

        // Random buttons, load values and occasional resets
        rs = 0;
        rr = 0;
        rl = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) rs = !rs;
            if ($urandom_range(0, 5) == 0) rr = !rr;
            if ($urandom_range(0, 4) == 0) rl = !rl;
            rst = ($urandom_range(0, 299) == 0);
            cyc(rst, rs, rr, rl, 3'($urandom_range(0, 7)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
